// File: rtl/game_status_tx_pkg.sv
// Shared definitions for the game status UART transmitter: event codes,
// packet header byte, FSM state encodings and the baud divisor helper.
package game_pkg;

  localparam logic [2:0] EV_COLL_B1 = 3'd0;
  localparam logic [2:0] EV_COLL_B2 = 3'd1;
  localparam logic [2:0] EV_ATTACK  = 3'd2;
  localparam logic [2:0] EV_STATE   = 3'd3;

  localparam logic [7:0] PKT_HDR = 8'hA5;

  typedef enum logic [2:0] {
    PK_IDLE,
    PK_HDR,
    PK_CODE,
    PK_DATA,
    PK_SUM
  } pk_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } b_state_t;

  // Clock cycles per serial bit, truncated.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/game_status_tx_if.sv
// Event push handshake plus serial/status outputs of the game status transmitter.
interface game_status_tx_if;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [6:0] ev_data;
  logic       ev_ready;
  logic       tx;
  logic       busy;
  logic [7:0] drop_cnt;

  modport master (
    output ev_valid, ev_code, ev_data,
    input  ev_ready, tx, busy, drop_cnt
  );

  modport slave (
    input  ev_valid, ev_code, ev_data,
    output ev_ready, tx, busy, drop_cnt
  );
endinterface

// File: rtl/game_status_tx_byte.sv
// 8N1 byte serializer. done is high during the last cycle of the stop bit so
// that a load presented in that cycle starts the next start bit with no gap.
module uart_tx_byte
  import game_pkg::*;
#(
  parameter int DIV = 2604
) (
  input  logic       Pclk,
  input  logic       RESET,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

  b_state_t       state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           accept;

  assign accept = load && ((state == B_IDLE) || ((state == B_STOP) && (cnt == CNT_LAST)));

  // Capture the byte to shift whenever a new frame is accepted.
  always_ff @(posedge Pclk) begin
    if (accept) shreg <= din;
  end

  // Byte framing FSM with per-bit baud counter and registered line output.
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      state   <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        B_IDLE: begin
          if (load) begin
            state <= B_START;
            cnt   <= '0;
            tx    <= 1'b0;
          end
        end
        B_START: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= B_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[3'(bit_idx + 3'd1)];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt == CNT_PRE) done <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (load) begin
              state <= B_START;
              tx    <= 1'b0;
            end else begin
              state <= B_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/game_status_tx.sv
// Game event reporter: queues {code, data} events in a small FIFO and sends
// each one as a 4-byte packet (A5, code, data, checksum) over 8N1 serial.
module game_status_tx
  import game_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input logic            Pclk,
  input logic            RESET,
  game_status_tx_if.slave bus
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop;
  logic [7:0]    drop_q;

  pk_state_t     pk_state;
  logic [2:0]    code_q;
  logic [6:0]    data_q;
  logic          kick, hdr_sent;
  logic          load, done, tx_bit;
  logic [7:0]    din;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.ev_valid && !full;
  assign pop   = (pk_state == PK_IDLE) && !empty;

  assign bus.ev_ready = !full;
  assign bus.busy     = (pk_state != PK_IDLE) || !empty;
  assign bus.tx       = tx_bit;
  assign bus.drop_cnt = drop_q;

  // FIFO storage write port.
  always_ff @(posedge Pclk) begin
    if (push) mem[wr_ptr] <= {bus.ev_code, bus.ev_data};
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.ev_valid && full && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Latch the popped event for the duration of its packet.
  always_ff @(posedge Pclk) begin
    if (pop) {code_q, data_q} <= mem[rd_ptr];
  end

  // Packet sequencer: header launched by kick, later bytes chained on done.
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      pk_state <= PK_IDLE;
      kick     <= 1'b0;
      hdr_sent <= 1'b0;
    end else begin
      kick <= 1'b0;
      case (pk_state)
        PK_IDLE: begin
          if (!empty) begin
            pk_state <= PK_HDR;
            hdr_sent <= 1'b0;
          end
        end
        PK_HDR: begin
          if (!hdr_sent) begin
            kick     <= 1'b1;
            hdr_sent <= 1'b1;
          end else if (done) begin
            pk_state <= PK_CODE;
          end
        end
        PK_CODE: if (done) pk_state <= PK_DATA;
        PK_DATA: if (done) pk_state <= PK_SUM;
        PK_SUM:  if (done) pk_state <= PK_IDLE;
        default: pk_state <= PK_IDLE;
      endcase
    end
  end

  // Byte offered to the serializer: header on kick, next byte on done.
  always_comb begin
    load = kick || (done && ((pk_state == PK_HDR) || (pk_state == PK_CODE) || (pk_state == PK_DATA)));
    din  = PKT_HDR;
    case (pk_state)
      PK_HDR:  din = kick ? PKT_HDR : {5'b0, code_q};
      PK_CODE: din = {1'b0, data_q};
      PK_DATA: din = {5'b0, code_q} ^ {1'b0, data_q};
      default: din = PKT_HDR;
    endcase
  end

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .Pclk  (Pclk),
    .RESET (RESET),
    .load  (load),
    .din   (din),
    .tx    (tx_bit),
    .done  (done)
  );

endmodule

// File: tb/tb_game_status_tx.sv
// Self-checking bench for game_status_tx: a serial-line monitor decodes bytes
// and compares them against a queue filled when events are driven.
module tb_game_status_tx;

  localparam int CLK_HZ     = 1600;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = CLK_HZ / BAUD;

  logic Pclk  = 1'b0;
  logic RESET = 1'b1;

  game_status_tx_if bus();

  game_status_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Pclk  (Pclk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 Pclk = ~Pclk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       mon_en  = 1'b0;
  logic       mon_act = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_mc = 0;
  int         mon_nbyte = 0;
  int         mon_last = 0;
  int         mon_cyc = 0;
  logic [7:0] mon_sh = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_event(input logic [2:0] c, input logic [6:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back({5'b0, c});
    exp_q.push_back({1'b0, d});
    exp_q.push_back({5'b0, c} ^ {1'b0, d});
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while ((bus.busy || mon_act) && (n < limit)) begin
      @(negedge Pclk);
      n++;
    end
    check({tag, "_idle_in_time"}, (n < limit), 1);
  endtask

  // Serial line monitor: samples each bit at its centre.
  initial begin
    forever begin
      @(negedge Pclk);
      mon_cyc++;
      if (!mon_en) begin
        mon_act   = 1'b0;
        mon_prev  = 1'b1;
        mon_nbyte = 0;
      end else if (!mon_act) begin
        if (mon_prev && !bus.tx) begin
          mon_act = 1'b1;
          mon_mc  = 0;
          if ((mon_nbyte % 4) != 0) check("byte_gap", mon_cyc - mon_last, 10 * DIV);
          mon_last = mon_cyc;
        end
        mon_prev = bus.tx;
      end else begin
        mon_mc++;
        if ((mon_mc % DIV) == (DIV / 2)) begin
          if (mon_mc / DIV == 0) begin
            check("start_bit", bus.tx, 0);
          end else if (mon_mc / DIV <= 8) begin
            mon_sh[mon_mc / DIV - 1] = bus.tx;
          end else begin
            check("stop_bit", bus.tx, 1);
            if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
            else check("rx_byte", mon_sh, exp_q.pop_front());
            mon_act  = 1'b0;
            mon_prev = 1'b1;
            mon_nbyte++;
          end
        end
      end
    end
  end

  initial begin
    int bad;
    int low;
    int n;
    logic run;
    bus.ev_valid = 1'b0;
    bus.ev_code  = 3'd0;
    bus.ev_data  = 7'd0;
    RESET = 1'b1;
    repeat (3) @(negedge Pclk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ev_ready, 1);
    check("rst_drop", bus.drop_cnt, 0);
    RESET  = 1'b0;
    mon_en = 1'b1;

    // Long idle after reset.
    bad = 0;
    repeat (10000) begin
      @(negedge Pclk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ev_ready !== 1'b1) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single attack event: latency, start-bit length and busy duration.
    @(negedge Pclk);
    bus.ev_valid = 1'b1; bus.ev_code = 3'd2; bus.ev_data = 7'd25;
    sb_event(3'd2, 7'd25);
    @(negedge Pclk);
    bus.ev_valid = 1'b0;
    check("lat_n0_tx", bus.tx, 1);
    check("lat_n0_busy", bus.busy, 1);
    @(negedge Pclk); check("lat_n1_tx", bus.tx, 1);
    @(negedge Pclk); check("lat_n2_tx", bus.tx, 1);
    @(negedge Pclk); check("lat_n3_tx", bus.tx, 0);
    low = 1;
    run = 1'b1;
    while (run && low < 4 * DIV) begin
      @(negedge Pclk);
      if (bus.tx === 1'b0) low++;
      else run = 1'b0;
    end
    check("start_len", low, DIV);
    repeat (40 * DIV - DIV - 1) @(negedge Pclk);
    check("busy_last", bus.busy, 1);
    @(negedge Pclk);
    check("busy_fall", bus.busy, 0);
    check("pkt1_drained", exp_q.size(), 0);

    // Reserved code passes through unchanged.
    @(negedge Pclk);
    bus.ev_valid = 1'b1; bus.ev_code = 3'd5; bus.ev_data = 7'h7F;
    sb_event(3'd5, 7'h7F);
    @(negedge Pclk);
    bus.ev_valid = 1'b0;
    wait_idle(50 * DIV, "rsv");
    check("rsv_drained", exp_q.size(), 0);

    // Six back-to-back pushes: five fit, the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge Pclk);
      if (i == 4) check("ready_room", bus.ev_ready, 1);
      if (i == 5) check("ready_full", bus.ev_ready, 0);
      bus.ev_valid = 1'b1;
      bus.ev_code  = 3'(i % 4);
      bus.ev_data  = (i == 3) ? 7'd1 : 7'(i * 9 + 3);
      if (i < 5) sb_event(3'(i % 4), (i == 3) ? 7'd1 : 7'(i * 9 + 3));
    end
    @(negedge Pclk);
    check("drop_one", bus.drop_cnt, 1);
    bus.ev_code = 3'd7;
    repeat (300) @(negedge Pclk);
    check("drop_sat", bus.drop_cnt, 255);
    check("ready_still_full", bus.ev_ready, 0);
    bus.ev_valid = 1'b0;
    wait_idle(6 * 44 * DIV, "burst");
    check("burst_drained", exp_q.size(), 0);
    check("drop_hold", bus.drop_cnt, 255);

    // Reset during data bit 3 of the third byte with two events queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge Pclk);
      bus.ev_valid = 1'b1;
      bus.ev_code  = 3'(i + 1);
      bus.ev_data  = 7'(10 * (i + 1));
    end
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    @(negedge Pclk);
    bus.ev_valid = 1'b0;
    n = 0;
    while (bus.tx === 1'b1 && n < 20) begin
      @(negedge Pclk);
      n++;
    end
    check("rst_pkt_started", (n < 20), 1);
    repeat (24 * DIV + DIV / 2) @(negedge Pclk);
    check("pre_reset_bytes", exp_q.size(), 0);
    RESET  = 1'b1;
    mon_en = 1'b0;
    @(negedge Pclk);
    check("midrst_tx", bus.tx, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ready", bus.ev_ready, 1);
    check("midrst_drop", bus.drop_cnt, 0);
    RESET  = 1'b0;
    mon_en = 1'b1;
    bad = 0;
    repeat (100 * DIV) begin
      @(negedge Pclk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
